loaded_fanout_tree: RTL and testbench
=====================================

# loaded_fanout_tree

Parametrised high-fanout register bank. It computes `in1 & in2` once and distributes the result to `NUM_LOADS` output flops through a pipelined tree of replicated registers. No register drives more than `MAX_FANOUT` loads. A second mode reuses the output flops as a serial shift register. It is the scalable successor of the fixed 16-load AND-to-DFF test design, used as an exercisable high-fanout netlist for buffering and repair flows.

## Interface
Parameters:
- `NUM_LOADS`, 16: number of output flops; must be ≥ 2.
- `MAX_FANOUT`, 4: maximum loads per tree register; must be ≥ 2.
- `LEVELS`, derived, not overridable: smallest L ≥ 1 with `MAX_FANOUT^L ≥ NUM_LOADS`. It is 2 for the defaults.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in1`, input, 1: operand A.
- `in2`, input, 1: operand B.
- `en`, input, 1: advance enable; when low, every register holds.
- `mode`, input, 1: 0 = broadcast, 1 = shift.
- `out`, output, `NUM_LOADS`: leaf flop outputs.
- `valid`, output, 1: the broadcast pipeline is filled and `out` reflects a coherent sample.

## Operation
- **Root register `r0`.** Captures `g = in1 & in2` when `en = 1`, in either mode.
- **Tree levels k = 1..LEVELS-1.**
  - Level k holds `ceil(NUM_LOADS / MAX_FANOUT^(LEVELS-k))` replicated registers.
  - Register j at level k loads register `j / MAX_FANOUT` of level k-1; level 0 is `r0`.
- **Leaf level.**
  - Broadcast mode: `out[i]` loads tree register `i / MAX_FANOUT` of level LEVELS-1. When LEVELS = 1, it loads `r0` directly.
  - Shift mode: `out <= {out[NUM_LOADS-2:0], r0}`. The tree registers keep advancing, but the leaves ignore them.
- **Fill counter `fill`.** Width is `$clog2(LEVELS+2)`.
  - Increments on every `en = 1` cycle with `mode = 0`.
  - Saturates at LEVELS+1.
  - `valid = (fill == LEVELS+1) && !mode`.
- **Mode change.** Any cycle where `mode` differs from its registered copy `mode_q` clears `fill` to 0, whatever the value of `en`.
- **`en = 0`.** All registers hold, including `fill`, `mode_q` and `out`; `valid` holds its value.
- **Reset.** `r0`, all tree registers, `out`, `fill` and `mode_q` go to 0, so `valid = 0`. Reset takes priority over `en` and mode change. A reset mid-fill or mid-shift discards all in-flight data.
- **Structural fanout rule.** No register output may feed more than `MAX_FANOUT` register inputs. Tree-level replicas must not be merged; synthesis must keep them (apply a keep attribute).

## Timing
- **Broadcast latency.** Inputs sampled at edge t appear on all `out` bits at edge t+LEVELS+1, counting `en = 1` cycles only. That is 3 cycles for the defaults and 2 cycles when `NUM_LOADS ≤ MAX_FANOUT`.
- **`valid` in broadcast.** Rises on the edge where the (LEVELS+1)-th consecutive enabled broadcast sample lands in `out`.
- **Shift latency.** A sample reaches `out[0]` 2 enabled cycles after being presented and `out[NUM_LOADS-1]` after NUM_LOADS+1 cycles. `valid` stays 0 throughout shift mode.
- **Combinational paths.** None from inputs to outputs; `out` and `valid` are register-driven or decoded from registers only.

## Structure
- Package `loaded_pkg` holds:
  - function `fanout_levels(num_loads, max_fanout)`, which computes LEVELS;
  - function `level_width(k, levels, num_loads, max_fanout)`;
  - localparams `MODE_BROADCAST = 1'b0` and `MODE_SHIFT = 1'b1`.
- Sub-module `fanout_stage`:
  - parameters `N_IN`, `N_OUT`, `MAX_FANOUT`;
  - one level of replicated registers with `en`/`rst`;
  - instantiated LEVELS-1 times in a generate loop. The leaf level is written inline because of the shift mux.

## Test plan
- **Reset.** `rst = 1` for 2 cycles with `in1 = in2 = 1`, `en = 1` → `out = 16'h0000`, `valid = 0`.
- **Broadcast.** Defaults, mode 0, `en = 1`, `in1 = in2 = 1` from cycle 0 → `out = 16'h0000` through cycle 2, then `out = 16'hFFFF` and `valid = 1` at cycle 3. Setting `in2 = 0` makes `out` return to `16'h0000` exactly 3 cycles later.
- **Enable stall.** Drop `en` for 5 cycles mid-fill at `fill = 1` → `out` and `fill` frozen; `valid` rises 2 enabled cycles after `en` returns.
- **Shift.** Mode 1, feed pattern 1,0,1,1 → after 5 enabled cycles `out[3:0] = 4'b1011`, with `out[0] = 1` last. `valid` is 0 throughout; returning to mode 0 clears `fill`, and `valid` rises 3 enabled cycles later.
- **Parameter sweep.** `(NUM_LOADS, MAX_FANOUT)` = (4,4), (17,4), (64,2) → latencies of 2, 4 and 7 cycles. A structural check confirms the fanout of every register is ≤ `MAX_FANOUT`.
- **Reset mid-operation.** Assert `rst` for one cycle while `out = 16'hFFFF` → `out = 0` and `valid = 0` on the next edge, and a full LEVELS+1 refill is required.

Source files
------------

// File: rtl/loaded_pkg.sv
// Shared elaboration helpers and mode encodings for the loaded fanout tree.
// Tree depth and per-level replica counts are computed here so every file agrees on them.
package loaded_pkg;

    localparam logic MODE_BROADCAST = 1'b0;
    localparam logic MODE_SHIFT     = 1'b1;

    // Smallest L >= 1 such that max_fanout^L >= num_loads.
    function automatic int fanout_levels(input int num_loads, input int max_fanout);
        int levels;
        int reach;
        levels = 1;
        reach  = max_fanout;
        for (int i = 0; i < 32; i++) begin
            if (reach < num_loads) begin
                levels = levels + 1;
                reach  = reach * max_fanout;
            end
        end
        return levels;
    endfunction

    // Replica count at tree level k: ceil(num_loads / max_fanout^(levels-k)).
    function automatic int level_width(input int k, input int levels,
                                       input int num_loads, input int max_fanout);
        int div;
        div = 1;
        for (int i = 0; i < 32; i++) begin
            if (i < (levels - k)) begin
                div = div * max_fanout;
            end
        end
        return (num_loads + div - 1) / div;
    endfunction

endpackage

// File: rtl/fanout_stage.sv
// One level of replicated registers: replica j copies source j / MAX_FANOUT,
// so no source bit drives more than MAX_FANOUT replicas.
module fanout_stage #(
    parameter int N_IN       = 1,
    parameter int N_OUT      = 4,
    parameter int MAX_FANOUT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N_IN-1:0]   d,
    output logic [N_OUT-1:0]  q
);

    (* keep = "true" *) logic [N_OUT-1:0] q_r;

    // Replica registers: cleared by reset, advance only when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= {N_OUT{1'b0}};
        end else if (en) begin
            for (int j = 0; j < N_OUT; j++) begin
                q_r[j] <= d[j / MAX_FANOUT];
            end
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/loaded_fanout_tree.sv
// High-fanout register bank: in1 & in2 is registered once, replicated through a
// pipelined tree, and lands in NUM_LOADS leaf flops (or shifts through them in shift mode).
module loaded_fanout_tree
    import loaded_pkg::*;
#(
    parameter int NUM_LOADS  = 16,
    parameter int MAX_FANOUT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in1,
    input  logic                 in2,
    input  logic                 en,
    input  logic                 mode,
    output logic [NUM_LOADS-1:0] out,
    output logic                 valid
);

    localparam int LEVELS     = fanout_levels(NUM_LOADS, MAX_FANOUT);
    localparam int LEAF_SRC_W = level_width(LEVELS - 1, LEVELS, NUM_LOADS, MAX_FANOUT);
    localparam int FILL_W     = $clog2(LEVELS + 2);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEVELS + 1);

    (* keep = "true" *) logic r0_r;
    logic [NUM_LOADS-1:0]  out_r;
    logic [NUM_LOADS-1:0]  out_nxt_s;
    logic [FILL_W-1:0]     fill_r;
    logic [FILL_W-1:0]     fill_nxt_s;
    logic                  mode_q_r;
    logic                  mode_q_nxt_s;
    logic                  valid_r;
    logic [LEAF_SRC_W-1:0] leaf_src_s;
    logic                  g_s;

    assign g_s = in1 & in2;

    generate
        if (LEVELS == 1) begin : g_no_tree
            assign leaf_src_s = r0_r;
        end else begin : g_tree
            for (genvar k = 1; k < LEVELS; k++) begin : g_lvl
                localparam int W_IN  = level_width(k - 1, LEVELS, NUM_LOADS, MAX_FANOUT);
                localparam int W_OUT = level_width(k, LEVELS, NUM_LOADS, MAX_FANOUT);
                logic [W_IN-1:0]  d_s;
                logic [W_OUT-1:0] q_s;

                if (k == 1) begin : g_first
                    assign d_s = r0_r;
                end else begin : g_next
                    assign d_s = g_lvl[k-1].q_s;
                end

                fanout_stage #(
                    .N_IN      (W_IN),
                    .N_OUT     (W_OUT),
                    .MAX_FANOUT(MAX_FANOUT)
                ) u_stage (
                    .clk(clk),
                    .rst(rst),
                    .en (en),
                    .d  (d_s),
                    .q  (q_s)
                );
            end
            assign leaf_src_s = g_lvl[LEVELS-1].q_s;
        end
    endgenerate

    // Leaf next-state: shift chain fed by r0, or broadcast from the last tree level.
    always_comb begin
        out_nxt_s = out_r;
        if (!en) begin
            out_nxt_s = out_r;
        end else if (mode == MODE_SHIFT) begin
            out_nxt_s = {out_r[NUM_LOADS-2:0], r0_r};
        end else begin
            for (int i = 0; i < NUM_LOADS; i++) begin
                out_nxt_s[i] = leaf_src_s[i / MAX_FANOUT];
            end
        end
    end

    // Fill tracking: a mode mismatch restarts the count even while stalled.
    always_comb begin
        fill_nxt_s   = fill_r;
        mode_q_nxt_s = mode_q_r;
        if (mode != mode_q_r) begin
            fill_nxt_s = {FILL_W{1'b0}};
        end else if (en && (mode == MODE_BROADCAST) && (fill_r != FILL_FULL)) begin
            fill_nxt_s = fill_r + 1'b1;
        end else begin
            fill_nxt_s = fill_r;
        end
        if (en) begin
            mode_q_nxt_s = mode;
        end else begin
            mode_q_nxt_s = mode_q_r;
        end
    end

    // Root, leaves and control state; valid is registered from the next fill/mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r0_r     <= 1'b0;
            out_r    <= {NUM_LOADS{1'b0}};
            fill_r   <= {FILL_W{1'b0}};
            mode_q_r <= 1'b0;
            valid_r  <= 1'b0;
        end else begin
            if (en) begin
                r0_r <= g_s;
            end else begin
                r0_r <= r0_r;
            end
            out_r    <= out_nxt_s;
            fill_r   <= fill_nxt_s;
            mode_q_r <= mode_q_nxt_s;
            valid_r  <= (fill_nxt_s == FILL_FULL) && (mode_q_nxt_s == MODE_BROADCAST);
        end
    end

    assign out   = out_r;
    assign valid = valid_r;

endmodule

// File: tb/tb_loaded_fanout_tree.sv
// Self-checking bench: four parameterisations driven in lockstep, compared each cycle
// against a sample-history model, plus directed literal checks on the default build.
module tb_loaded_fanout_tree;
    import loaded_pkg::*;

    logic clk = 1'b0;
    logic rst, in1, in2, en, mode;
    logic [15:0] o0;
    logic [3:0]  o1;
    logic [16:0] o2;
    logic [63:0] o3;
    logic [3:0]  v;
    logic [63:0] dout [4];

    always #5 clk = ~clk;

    loaded_fanout_tree u_d0 (.clk(clk), .rst(rst), .in1(in1), .in2(in2), .en(en), .mode(mode), .out(o0), .valid(v[0]));
    loaded_fanout_tree #(.NUM_LOADS(4), .MAX_FANOUT(4)) u_d1 (.clk(clk), .rst(rst), .in1(in1), .in2(in2), .en(en), .mode(mode), .out(o1), .valid(v[1]));
    loaded_fanout_tree #(.NUM_LOADS(17), .MAX_FANOUT(4)) u_d2 (.clk(clk), .rst(rst), .in1(in1), .in2(in2), .en(en), .mode(mode), .out(o2), .valid(v[2]));
    loaded_fanout_tree #(.NUM_LOADS(64), .MAX_FANOUT(2)) u_d3 (.clk(clk), .rst(rst), .in1(in1), .in2(in2), .en(en), .mode(mode), .out(o3), .valid(v[3]));

    always_comb begin
        dout[0] = {48'd0, o0};
        dout[1] = {60'd0, o1};
        dout[2] = {47'd0, o2};
        dout[3] = o3;
    end

    int nl [4] = '{16, 4, 17, 64};
    int mf [4] = '{4, 4, 4, 2};
    int lv [4] = '{2, 1, 3, 6};   // hand-derived depths: latency = lv + 1
    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    // Model: history of captured samples (hist[0] = newest), leaf contents, fill counts.
    logic [7:0]  hist;
    logic [63:0] mout [4];
    int          mfill [4];
    logic        mq;

    function automatic logic [63:0] maskof(input int n);
        if (n >= 64) return {64{1'b1}};
        return (64'd1 << n) - 64'd1;
    endfunction

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            hist <= 8'd0;
            mq   <= 1'b0;
            for (int d = 0; d < 4; d++) begin
                mout[d]  <= 64'd0;
                mfill[d] <= 0;
            end
        end else begin
            for (int d = 0; d < 4; d++) begin
                if (mode != mq) mfill[d] <= 0;
                else if (en && !mode && mfill[d] < lv[d] + 1) mfill[d] <= mfill[d] + 1;
                if (en) begin
                    if (mode) mout[d] <= ((mout[d] << 1) | {63'd0, hist[0]}) & maskof(nl[d]);
                    else      mout[d] <= hist[lv[d]-1] ? maskof(nl[d]) : 64'd0;
                end
            end
            if (en) begin
                hist <= {hist[6:0], in1 & in2};
                mq   <= mode;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int d = 0; d < 4; d++) begin
                check64($sformatf("model_out%0d", d), dout[d], mout[d]);
                check64($sformatf("model_valid%0d", d), {63'd0, v[d]},
                        {63'd0, (mfill[d] == lv[d] + 1) && !mq});
            end
        end
    end

    logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        rst = 1'b1; in1 = 1'b1; in2 = 1'b1; en = 1'b1; mode = 1'b0;

        // Depth helper and structural fanout bound for every configuration.
        for (int d = 0; d < 4; d++) begin
            check64($sformatf("levels%0d", d), 64'(fanout_levels(nl[d], mf[d])), 64'(lv[d]));
            check64($sformatf("root_w%0d", d), 64'(level_width(0, lv[d], nl[d], mf[d])), 64'd1);
            for (int k = 1; k < lv[d]; k++)
                check64($sformatf("fanout%0d_l%0d", d, k),
                        64'(level_width(k, lv[d], nl[d], mf[d]) <= level_width(k-1, lv[d], nl[d], mf[d]) * mf[d]), 64'd1);
            check64($sformatf("leaf_fanout%0d", d),
                    64'(nl[d] <= level_width(lv[d]-1, lv[d], nl[d], mf[d]) * mf[d]), 64'd1);
        end
        check64("lvl1_width_default", 64'(level_width(1, 2, 16, 4)), 64'd4);

        step; chk_on = 1'b1; step;
        check64("reset_out", dout[0], 64'h0);
        check64("reset_valid", {60'd0, v}, 64'h0);

        // Broadcast from cycle 0.
        rst = 1'b0;
        step; check64("bc_e1", dout[0], 64'h0);
        step; check64("bc_e2", dout[0], 64'h0);
        check64("bc_e2_small", dout[1], 64'hF);
        step; check64("bc_e3", dout[0], 64'hFFFF);
        check64("bc_e3_valid", {63'd0, v[0]}, 64'd1);
        in2 = 1'b0;
        step; step; check64("bc_fall_e2", dout[0], 64'hFFFF);
        step; check64("bc_fall_e3", dout[0], 64'h0);

        // Enable stall at fill = 1.
        rst = 1'b1; step; rst = 1'b0; in2 = 1'b1;
        step;
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step;
            check64("stall_out", dout[0], 64'h0);
            check64("stall_valid", {63'd0, v[0]}, 64'd0);
        end
        en = 1'b1;
        step; check64("stall_resume1_valid", {63'd0, v[0]}, 64'd0);
        step; check64("stall_resume2_valid", {63'd0, v[0]}, 64'd1);
        check64("stall_resume2_out", dout[0], 64'hFFFF);

        // Shift mode: pattern 1,0,1,1.
        mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in2 = pat[i];
            step;
            check64("shift_valid", {63'd0, v[0]}, 64'd0);
        end
        check64("shift_nibble", {60'd0, dout[0][3:0]}, 64'hB);

        // Back to broadcast: fill restarts.
        mode = 1'b0; in2 = 1'b1;
        step; check64("ret_clear_valid", {63'd0, v[0]}, 64'd0);
        step; step; step;
        check64("ret_valid", {63'd0, v[0]}, 64'd1);
        check64("ret_out", dout[0], 64'hFFFF);

        // Reset mid-operation requires a full refill.
        rst = 1'b1; step;
        check64("midrst_out", dout[0], 64'h0);
        check64("midrst_valid", {63'd0, v[0]}, 64'd0);
        rst = 1'b0;
        step; step; check64("refill_e2", dout[0], 64'h0);
        step; check64("refill_e3", dout[0], 64'hFFFF);
        check64("refill_valid", {63'd0, v[0]}, 64'd1);

        // Randomized traffic checked by the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            en  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            in1 = 1'($urandom_range(0, 1));
            in2 = 1'($urandom_range(0, 3) != 0);
            step;
        end

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
